sprite_anim_rom: RTL and testbench
==================================

SPRITE_ANIM_ROM -- requirements
Module: sprite_anim_rom

Interface
REQ-001 SHALL have parameter SPRITE_W, default 8, meaning bitmap width in pixels (sprite columns).
REQ-002 SHALL have parameter SPRITE_H, default 8, meaning bitmap height in rows.
REQ-003 SHALL have parameter NUM_FRAMES, default 2, meaning number of animation frames.
REQ-004 SHALL have parameter SCALE_LOG2, default 1, meaning each bitmap pixel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
REQ-005 SHALL have parameter ANIM_DIV, default 16, meaning frame_tick pulses per animation step.
REQ-006 SHALL have parameter EXPLODE_TICKS, default 8, meaning frame_tick pulses the explosion bitmap is shown.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-009 SHALL have port frame_tick, input, 1, meaning one-cycle pulse once per video frame.
REQ-010 SHALL have port kill, input, 1, meaning one-cycle hit pulse.
REQ-011 SHALL have port revive, input, 1, meaning one-cycle respawn pulse.
REQ-012 SHALL have ports pix_x and pix_y, input, 10 each, meaning current beam position.
REQ-013 SHALL have ports spr_x and spr_y, input, 10 each, meaning sprite top-left screen position.
REQ-014 SHALL have port mirror, input, 1, meaning horizontal flip request.
REQ-015 SHALL have port pixel_on, output, 1, meaning registered sprite pixel for the beam position.
REQ-016 SHALL have port exploding, output, 1, meaning FSM in EXPLODE.
REQ-017 SHALL have port dead, output, 1, meaning FSM in DEAD.
REQ-018 SHALL have port frame_idx, output, clog2(NUM_FRAMES) (min 1), meaning current animation frame.

Function
REQ-019 SHALL hold NUM_FRAMES animation bitmaps plus one explosion bitmap in an internal constant table, row 0 at top, column 0 = row-word MSB.
REQ-020 SHALL contain frame 0 default rows 0..7: 00011000, 00111100, 01111110, 11011011, 11111111, 00100100, 01000010, 10000001; frame 1 equal to frame 0 except rows 5..7 = 01011010, 10000001, 01000010.
REQ-021 SHALL implement FSM ALIVE, EXPLODE, DEAD; ALIVE -> EXPLODE on kill; EXPLODE -> DEAD on the frame_tick that brings the explode counter to EXPLODE_TICKS; DEAD -> ALIVE on revive.
REQ-022 SHALL, in ALIVE, count frame_tick pulses 0..ANIM_DIV-1 and on wrap advance frame_idx modulo NUM_FRAMES.
REQ-023 SHALL on entry to EXPLODE clear the explode counter; on entry to ALIVE clear anim counter and frame_idx.
REQ-024 SHALL give kill priority over a simultaneous frame_tick in ALIVE, ignore kill and revive in EXPLODE, ignore kill in DEAD, and ignore revive in ALIVE.
REQ-025 SHALL compute hit when spr_x <= pix_x < spr_x + (SPRITE_W << SCALE_LOG2) and likewise for y, using 11-bit arithmetic so no wrap; sprite portions beyond 1023 are clipped.
REQ-026 SHALL select row = (pix_y - spr_y) >> SCALE_LOG2 and col = (pix_x - spr_x) >> SCALE_LOG2.
REQ-027 SHALL register pixel_on = hit AND bitmap bit, one clk latency from pix_x/pix_y; bitmap = frame_idx frame in ALIVE, explosion bitmap in EXPLODE; pixel_on = 0 in DEAD.
REQ-028 SHALL assert exploding and dead as registered decodes of the FSM state.

Reset
REQ-029 SHALL on reset assert asynchronously force state ALIVE, frame_idx 0, both counters 0, pixel_on 0, exploding 0, dead 0.
REQ-030 SHALL, on reset mid-explosion, abort the explosion and resume ALIVE frame 0 after release.

Configuration
REQ-031 SHALL, with SPRITE_MIRROR_EN defined, use col' = SPRITE_W-1-col when mirror = 1.
REQ-032 SHALL, without SPRITE_MIRROR_EN, keep port mirror but ignore it (no flip logic).

Verification
REQ-033 SHALL check spr=(100,50), SCALE_LOG2=1, beam (106,50) -> pixel_on=1 next cycle; beam (104,50) -> 0; (100,49) -> 0.
REQ-034 SHALL check 16 frame_ticks in ALIVE -> frame_idx 0->1; 32 -> back to 0.
REQ-035 SHALL check kill and frame_tick same cycle -> exploding=1, frame_idx unchanged; 8 further frame_ticks -> dead=1, pixel_on=0 everywhere.
REQ-036 SHALL check revive in DEAD -> ALIVE, frame_idx 0; kill during EXPLODE -> counter not restarted.
REQ-037 SHALL check reset pulse mid-EXPLODE -> all outputs 0 immediately without clk edge.
REQ-038 SHALL check with SPRITE_MIRROR_EN, mirror=1, frame 0 row 3 at SCALE_LOG2=0 col 2 -> 0, col 3 -> 1 (row 3 symmetric, so equals unmirrored); row 5 frame 1 col 1 vs col 6 swapped.

Source files
------------

// File: rtl/sprite_anim_rom.sv
// sprite_anim_rom: animated bitmap sprite with an ALIVE / EXPLODE / DEAD life cycle.
// The beam position is compared against the sprite rectangle. The selected bitmap
// bit is registered onto pixel_on one clock after pix_x/pix_y.
// Optional build macro: SPRITE_MIRROR_EN enables the horizontal flip driven by
// the mirror input. Without it, mirror is accepted and ignored.
// Bitmaps are 8x8 glyphs. Other SPRITE_W/SPRITE_H values tile the glyph modulo 8.
module sprite_anim_rom #(
    parameter int SPRITE_W      = 8,
    parameter int SPRITE_H      = 8,
    parameter int NUM_FRAMES    = 2,
    parameter int SCALE_LOG2    = 1,
    parameter int ANIM_DIV      = 16,
    parameter int EXPLODE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       kill,
    input  logic       revive,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] spr_x,
    input  logic [9:0] spr_y,
    input  logic       mirror,
    output logic       pixel_on,
    output logic       exploding,
    output logic       dead,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx
);

    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    // The explode counter must be able to hold EXPLODE_TICKS itself.
    localparam int EW = $clog2(EXPLODE_TICKS + 1);

    // On-screen footprint of the sprite in pixels.
    localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_LOG2);

    // Glyph rows, row 0 in the top byte, column 0 at each row's MSB.
    // NOTE: the glyphs are constants, so there is nothing to reset or initialise.
    localparam logic [63:0] FRAME0_ROWS = {
        8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
        8'b11111111, 8'b00100100, 8'b01000010, 8'b10000001
    };
    localparam logic [63:0] FRAME1_ROWS = {
        8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
        8'b11111111, 8'b01011010, 8'b10000001, 8'b01000010
    };
    // The explosion shape is deliberately asymmetric, so a horizontal flip is visible.
    localparam logic [63:0] BOOM_ROWS = {
        8'b10001000, 8'b01001001, 8'b00101010, 8'b11000100,
        8'b00100011, 8'b01010100, 8'b10010010, 8'b00010001
    };

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_EXPLODE = 2'd1,
        ST_DEAD    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
    logic [EW-1:0]   expl_cnt_q, expl_cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            pixel_q, pixel_d;
    logic            exploding_q, exploding_d;
    logic            dead_q, dead_d;

    logic [10:0]     beam_x, beam_y, org_x, org_y;
    logic            hit_x, hit_y;
    logic [9:0]      dx, dy, col_w, row_w;
    logic            glyph;

    // Returns one bit of an 8x8 glyph; row and column wrap modulo 8.
    function automatic logic glyph_bit(input logic [63:0] rows,
                                       input logic [2:0]  r,
                                       input logic [2:0]  c);
        return rows[6'd63 - {r, c}];
    endfunction

    // State register: FSM, counters and every registered output.
    // NOTE: clocked blocks use non-blocking assignments so that all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ALIVE;
            anim_cnt_q  <= '0;
            expl_cnt_q  <= '0;
            frame_q     <= '0;
            pixel_q     <= 1'b0;
            exploding_q <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            anim_cnt_q  <= anim_cnt_d;
            expl_cnt_q  <= expl_cnt_d;
            frame_q     <= frame_d;
            pixel_q     <= pixel_d;
            exploding_q <= exploding_d;
            dead_q      <= dead_d;
        end
    end

    // Next-state logic: life-cycle transitions and the animation/explosion counters.
    always_comb begin
        // NOTE: every variable gets a hold value first, so no path can infer a latch.
        state_d    = state_q;
        anim_cnt_d = anim_cnt_q;
        expl_cnt_d = expl_cnt_q;
        frame_d    = frame_q;
        case (state_q)
            ST_ALIVE: begin
                // A hit wins over a simultaneous frame tick, and the frame index stays frozen.
                if (kill) begin
                    state_d    = ST_EXPLODE;
                    expl_cnt_d = '0;
                end else if (frame_tick) begin
                    if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
                        anim_cnt_d = '0;
                        frame_d    = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
                    end else begin
                        anim_cnt_d = anim_cnt_q + AW'(1);
                    end
                end
            end
            ST_EXPLODE: begin
                // kill and revive are ignored here, so a second hit never restarts the count.
                if (frame_tick) begin
                    expl_cnt_d = expl_cnt_q + EW'(1);
                    if (expl_cnt_q == EW'(EXPLODE_TICKS - 1)) begin
                        state_d = ST_DEAD;
                    end
                end
            end
            ST_DEAD: begin
                if (revive) begin
                    state_d    = ST_ALIVE;
                    anim_cnt_d = '0;
                    frame_d    = '0;
                end
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    // Beam-to-sprite address decode. The 11-bit compares keep the right edge from wrapping past 1023.
    always_comb begin
        beam_x = {1'b0, pix_x};
        beam_y = {1'b0, pix_y};
        org_x  = {1'b0, spr_x};
        org_y  = {1'b0, spr_y};
        hit_x  = (beam_x >= org_x) && (beam_x < org_x + SPAN_X);
        hit_y  = (beam_y >= org_y) && (beam_y < org_y + SPAN_Y);
        dx     = pix_x - spr_x;
        dy     = pix_y - spr_y;
        col_w  = dx >> SCALE_LOG2;
        row_w  = dy >> SCALE_LOG2;
`ifdef SPRITE_MIRROR_EN
        if (mirror) begin
            col_w = 10'(SPRITE_W - 1) - col_w;
        end
`endif
    end

    // Output decode: bitmap selection by state, plus the next values of the status flags.
    always_comb begin
        exploding_d = (state_d == ST_EXPLODE);
        dead_d      = (state_d == ST_DEAD);
        glyph       = 1'b0;
        case (state_q)
            ST_ALIVE:   glyph = glyph_bit(frame_q[0] ? FRAME1_ROWS : FRAME0_ROWS,
                                          row_w[2:0], col_w[2:0]);
            ST_EXPLODE: glyph = glyph_bit(BOOM_ROWS, row_w[2:0], col_w[2:0]);
            default:    glyph = 1'b0;
        endcase
        pixel_d = hit_x & hit_y & glyph;
    end

    // Address bits above the glyph size only matter through the hit test.
`ifdef SPRITE_MIRROR_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^{row_w[9:3], col_w[9:3]};
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{row_w[9:3], col_w[9:3], mirror};
`endif

    assign pixel_on  = pixel_q;
    assign exploding = exploding_q;
    assign dead      = dead_q;
    assign frame_idx = frame_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// tb_sprite_anim_rom: directed stimulus for sprite_anim_rom.
// A spec-level model is checked every cycle against two instances (SCALE_LOG2 = 1 and 0).
// Literal expectations pin the model itself.
// Define SPRITE_MIRROR_EN for both the RTL and this bench to exercise the flip.
module tb_sprite_anim_rom;

    localparam int ANIM_DIV      = 16;
    localparam int EXPLODE_TICKS = 8;
    localparam int NUM_FRAMES    = 2;

    localparam logic [7:0] F0   [8] = '{8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
                                        8'b11111111, 8'b00100100, 8'b01000010, 8'b10000001};
    localparam logic [7:0] F1   [8] = '{8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
                                        8'b11111111, 8'b01011010, 8'b10000001, 8'b01000010};
    localparam logic [7:0] BOOM [8] = '{8'b10001000, 8'b01001001, 8'b00101010, 8'b11000100,
                                        8'b00100011, 8'b01010100, 8'b10010010, 8'b00010001};

    logic       clk, reset, frame_tick, kill, revive, mirror;
    logic [9:0] pix_x, pix_y, spr_x, spr_y;
    logic       pixel_on, exploding, dead;
    logic [0:0] frame_idx;
    logic       pixel_on_s0, exploding_s0, dead_s0;
    logic [0:0] frame_idx_s0;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Model state: 0 = alive, 1 = exploding, 2 = dead.
    int   m_st, m_anim, m_frm, m_ecnt;
    logic m_pix1, m_pix0;

    sprite_anim_rom #(.SCALE_LOG2(1)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .kill(kill), .revive(revive),
        .pix_x(pix_x), .pix_y(pix_y), .spr_x(spr_x), .spr_y(spr_y), .mirror(mirror),
        .pixel_on(pixel_on), .exploding(exploding), .dead(dead), .frame_idx(frame_idx)
    );

    sprite_anim_rom #(.SCALE_LOG2(0)) dut_s0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .kill(kill), .revive(revive),
        .pix_x(pix_x), .pix_y(pix_y), .spr_x(spr_x), .spr_y(spr_y), .mirror(mirror),
        .pixel_on(pixel_on_s0), .exploding(exploding_s0), .dead(dead_s0),
        .frame_idx(frame_idx_s0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected sprite pixel from the rectangle, scale, state and bitmap rules.
    function automatic logic model_pix(input int scale, input int px, input int py,
                                       input int sx, input int sy, input int st, input int frm);
        int w, r, c;
        logic [7:0] word;
        w = 8 << scale;
        if (st == 2) return 1'b0;
        if (px < sx || px >= sx + w || py < sy || py >= sy + w) return 1'b0;
        r = (py - sy) >> scale;
        c = (px - sx) >> scale;
`ifdef SPRITE_MIRROR_EN
        if (mirror) c = 7 - c;
`endif
        if (st == 1)           word = BOOM[r];
        else if (frm % 2 == 1) word = F1[r];
        else                   word = F0[r];
        return word[7 - c];
    endfunction

    // Behavioural model of the life cycle and of the registered pixel.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= 0; m_anim <= 0; m_frm <= 0; m_ecnt <= 0;
            m_pix1 <= 1'b0; m_pix0 <= 1'b0;
        end else begin
            m_pix1 <= model_pix(1, int'(pix_x), int'(pix_y), int'(spr_x), int'(spr_y), m_st, m_frm);
            m_pix0 <= model_pix(0, int'(pix_x), int'(pix_y), int'(spr_x), int'(spr_y), m_st, m_frm);
            if (m_st == 0) begin
                if (kill) begin
                    m_st <= 1; m_ecnt <= 0;
                end else if (frame_tick) begin
                    if (m_anim + 1 == ANIM_DIV) begin
                        m_anim <= 0; m_frm <= (m_frm + 1) % NUM_FRAMES;
                    end else begin
                        m_anim <= m_anim + 1;
                    end
                end
            end else if (m_st == 1) begin
                if (frame_tick) begin
                    m_ecnt <= m_ecnt + 1;
                    if (m_ecnt + 1 == EXPLODE_TICKS) m_st <= 2;
                end
            end else if (revive) begin
                m_st <= 0; m_anim <= 0; m_frm <= 0;
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (started && !reset) begin
            check("pixel_on",     pixel_on,          m_pix1);
            check("exploding",    exploding,         m_st == 1);
            check("dead",         dead,              m_st == 2);
            check("frame_idx",    int'(frame_idx),   m_frm);
            check("pixel_on_s0",  pixel_on_s0,       m_pix0);
            check("exploding_s0", exploding_s0,      m_st == 1);
            check("dead_s0",      dead_s0,           m_st == 2);
            check("frame_idx_s0", int'(frame_idx_s0), m_frm);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_kill();
        kill = 1'b1; step(); kill = 1'b0;
    endtask

    task automatic pulse_revive();
        revive = 1'b1; step(); revive = 1'b0;
    endtask

    // Drive a beam position and check the pixel registered at the next edge.
    task automatic beam(input string name, input int x, input int y, input int exp);
        pix_x = 10'(x); pix_y = 10'(y);
        step();
        check(name, pixel_on, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit;
        reset = 1'b1; frame_tick = 1'b0; kill = 1'b0; revive = 1'b0; mirror = 1'b0;
        pix_x = '0; pix_y = '0; spr_x = 10'd100; spr_y = 10'd50;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset pixel_on", pixel_on, 0);
        check("reset exploding", exploding, 0);
        check("reset dead", dead, 0);
        check("reset frame_idx", int'(frame_idx), 0);
        reset = 1'b0;
        started = 1'b1;
        step();

        // Hit window at 2x scale.
        beam("hit (106,50)", 106, 50, 1);
        beam("col2 (104,50)", 104, 50, 0);
        beam("above (100,49)", 100, 49, 0);
        beam("row3 col0 (100,56)", 100, 56, 1);
        beam("right edge (116,50)", 116, 50, 0);

        // Right-edge clipping: there is no wrap past column 1023.
        spr_x = 10'd1020;
        beam("clip (1023,56)", 1023, 56, 1);
        beam("no wrap (2,56)", 2, 56, 0);
        spr_x = 10'd100;

`ifdef SPRITE_MIRROR_EN
        mirror = 1'b1;
        pix_x = 10'd102; pix_y = 10'd53; step();
        check("mirror s0 row3 col2", pixel_on_s0, 0);
        pix_x = 10'd103; step();
        check("mirror s0 row3 col3", pixel_on_s0, 1);
        mirror = 1'b0;
`endif

        // Animation: 16 ticks per frame step, wrapping modulo two frames.
        tick(16);
        check("16 ticks frame", int'(frame_idx), 1);
        beam("frame1 row5 col1", 102, 60, 1);
        tick(16);
        check("32 ticks frame", int'(frame_idx), 0);
        beam("frame0 row5 col1", 102, 60, 0);

        // A kill arriving with a frame tick takes priority and freezes frame_idx at 1.
        tick(16);
        tick(3);
        kill = 1'b1; frame_tick = 1'b1; step(); kill = 1'b0; frame_tick = 1'b0;
        check("kill exploding", exploding, 1);
        check("kill frame_idx", int'(frame_idx), 1);
        beam("boom row0 col0", 100, 50, 1);
`ifdef SPRITE_MIRROR_EN
        mirror = 1'b1;
        beam("boom mirrored row0 col0", 100, 50, 0);
        mirror = 1'b0;
`endif
        revive = 1'b1; tick(3); revive = 1'b0;
        pulse_kill();
        tick(4);
        check("7 ticks still exploding", exploding, 1);
        check("7 ticks not dead", dead, 0);
        tick(1);
        check("8 ticks dead", dead, 1);
        check("8 ticks exploding off", exploding, 0);

        // Nothing is drawn while dead.
        lit = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                pix_x = 10'(100 + x); pix_y = 10'(50 + y);
                step();
                lit += int'(pixel_on);
            end
        end
        check("dead pixels lit", lit, 0);

        pulse_kill();
        check("kill ignored in dead", dead, 1);
        pulse_revive();
        check("revive dead", dead, 0);
        check("revive frame_idx", int'(frame_idx), 0);
        tick(3);
        pulse_revive();
        tick(13);
        check("revive ignored in alive", int'(frame_idx), 1);

        // Reset mid-explosion clears the outputs without waiting for a clock edge.
        pulse_kill();
        tick(2);
        beam("boom before reset", 100, 50, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset pixel_on", pixel_on, 0);
        check("async reset exploding", exploding, 0);
        check("async reset dead", dead, 0);
        check("async reset frame_idx", int'(frame_idx), 0);
        #1 reset = 1'b0;
        step();
        check("after reset alive", exploding, 0);
        check("after reset pixel frame0", pixel_on, 0);
        tick(16);
        check("after reset anim restarts", int'(frame_idx), 1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
